// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display.
// Holds one hex value and decimal point per digit and scans the enabled digits with a blanking gap.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [3:0] wr_data_i,
  input  logic       wr_dp_i,
  input  logic [7:0] dig_en_i,
  input  logic       lz_supp_i,
  output logic [7:0] seg_o,
  output logic [7:0] an_o,
  output logic [2:0] scan_idx_o,
  output logic       frame_done_o,
  output logic [1:0] state_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    pat_q;
  logic [7:0]    an_q;
  logic [7:0]    seg_q;
  logic          fd_q;

  logic [3:0]    val_q [8];
  logic [7:0]    dp_q;

  logic [2:0]    low_idx;
  logic          low_found;
  logic [2:0]    nxt_idx;
  logic          nxt_wrap;
  logic          lz_blank;
  logic [7:0]    pat_d;
  logic [7:0]    drive_an;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Digit storage; reset wins over a write landing on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) val_q[i] <= 4'd0;
      dp_q <= 8'd0;
    end else if (wr_en_i) begin
      val_q[wr_addr_i] <= wr_data_i;
      dp_q[wr_addr_i]  <= wr_dp_i;
    end
  end

  // Index selection and the pattern for the digit about to be driven.
  always_comb begin
    low_idx   = 3'd0;
    low_found = 1'b0;
    nxt_wrap  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (dig_en_i[j] && !low_found) begin
        low_idx   = 3'(j);
        low_found = 1'b1;
      end
    end
    nxt_idx = low_idx;
    for (int j = 7; j >= 0; j--) begin
      if (dig_en_i[j] && (3'(j) > idx_q)) begin
        nxt_idx  = 3'(j);
        nxt_wrap = 1'b0;
      end
    end
    lz_blank = lz_supp_i && (idx_q != low_idx) && (val_q[idx_q] == 4'd0) && !dp_q[idx_q];
    for (int j = 0; j < 8; j++) begin
      if (dig_en_i[j] && (3'(j) > idx_q) && ((val_q[j] != 4'd0) || dp_q[j]))
        lz_blank = 1'b0;
    end
    pat_d    = lz_blank ? 8'hFF : {~dp_q[idx_q], hex7(val_q[idx_q])};
    drive_an = ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pat_q   <= 8'hFF;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (dig_en_i == 8'd0) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        an_q    <= 8'hFF;
        seg_q   <= 8'hFF;
      end else begin
        case (state_q)
          S_IDLE: begin
            idx_q   <= low_idx;
            cnt_q   <= '0;
            state_q <= S_BLANK;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
          end
          S_BLANK: begin
            cnt_q <= cnt_q + CW'(1);
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
            if (cnt_q == BLANK_LAST) begin
              pat_q   <= pat_d;
              state_q <= S_DRIVE;
              if (dig_en_i[idx_q]) begin
                an_q  <= drive_an;
                seg_q <= pat_d;
              end
            end
          end
          S_DRIVE: begin
            if (cnt_q == DIV_LAST) begin
              cnt_q   <= '0;
              idx_q   <= nxt_idx;
              state_q <= S_BLANK;
              an_q    <= 8'hFF;
              seg_q   <= 8'hFF;
              // Wrapping back to the lowest index means the highest digit just finished.
              fd_q    <= nxt_wrap;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (dig_en_i[idx_q]) begin
                an_q  <= drive_an;
                seg_q <= pat_q;
              end else begin
                an_q  <= 8'hFF;
                seg_q <= 8'hFF;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
          end
        endcase
      end
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign scan_idx_o   = idx_q;
  assign frame_done_o = fd_q;
  assign state_o      = state_q;

endmodule
